gowin_rpll: RTL and testbench



---
 rtl/gowin_rpll_if.sv | 8 +
 rtl/gowin_rpll.sv | 70 +++++++
 tb/tb_gowin_rpll.sv | 98 +++++++++
 3 files changed

// File: rtl/gowin_rpll_if.sv
// gowin_rpll_if: generated clock outputs of gowin_rpll (clkout, lock, clkoutd)
interface gowin_rpll_if;
    logic clkout;
    logic lock;
    logic clkoutd;
    modport master (output clkout, lock, clkoutd);
    modport slave (input clkout, lock, clkoutd);
endinterface

// File: rtl/gowin_rpll.sv
// gowin_rpll: NCO clock generator, clkout averages f_clkin*MULT/DIV with sticky lock.
// Define GOWIN_RPLL_CLKOUTD_EN to build the clkout/SDIV secondary output clkoutd.
module gowin_rpll #(
    parameter int MULT = 1,
    parameter int DIV = 2,
    parameter int LOCK_CYCLES = 16,
    parameter int SDIV = 2
) (
    input logic clkin,
    input logic reset,
    gowin_rpll_if.master pll
);
    if (MULT < 1 || MULT > 32767 || DIV < 2 * MULT || DIV > 65535 ||
        LOCK_CYCLES < 1 || LOCK_CYCLES > 65535 ||
        SDIV < 2 || SDIV > 128 || (SDIV % 2) != 0) begin : g_bad_params
        $error("gowin_rpll: illegal parameters MULT=%0d DIV=%0d LOCK_CYCLES=%0d SDIV=%0d",
               MULT, DIV, LOCK_CYCLES, SDIV);
    end
    logic [15:0] acc_q, acc_d, lcnt_q, lcnt_d;
    logic clkout_q, clkout_d, lock_q, lock_d;
    logic [16:0] sum;
    logic wrap, rise;
    // 2*MULT <= DIV, so the accumulator wraps at most once per clkin cycle
    always_comb begin
        sum = {1'b0, acc_q} + 17'(2 * MULT);
        wrap = sum >= 17'(DIV);
        rise = wrap && !clkout_q;
        acc_d = wrap ? 16'(sum - 17'(DIV)) : sum[15:0];
        clkout_d = clkout_q ^ wrap;
        lcnt_d = (rise && lcnt_q != 16'(LOCK_CYCLES)) ? lcnt_q + 16'd1 : lcnt_q;
        lock_d = lock_q | (rise && lcnt_q == 16'(LOCK_CYCLES - 1));
    end
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            clkout_q <= 1'b0;
            lcnt_q <= '0;
            lock_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            clkout_q <= clkout_d;
            lcnt_q <= lcnt_d;
            lock_q <= lock_d;
        end
    end
    assign pll.clkout = clkout_q;
    assign pll.lock = lock_q;
`ifdef GOWIN_RPLL_CLKOUTD_EN
    logic [6:0] dcnt_q, dcnt_d;
    logic clkoutd_q, clkoutd_d;
    logic dwrap;
    always_comb begin
        dwrap = rise && dcnt_q == 7'(SDIV / 2 - 1);
        dcnt_d = rise ? (dwrap ? 7'd0 : dcnt_q + 7'd1) : dcnt_q;
        clkoutd_d = clkoutd_q ^ dwrap;
    end
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            dcnt_q <= '0;
            clkoutd_q <= 1'b0;
        end else begin
            dcnt_q <= dcnt_d;
            clkoutd_q <= clkoutd_d;
        end
    end
    assign pll.clkoutd = clkoutd_q;
`else
    assign pll.clkoutd = 1'b0;
`endif
endmodule

// File: tb/tb_gowin_rpll.sv
// tb_gowin_rpll: four gowin_rpll configurations against a closed-form frequency model.
module tb_gowin_rpll;
    logic clkin = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    int n = 0;
    always #5 clkin = ~clkin;
    gowin_rpll_if if0 ();
    gowin_rpll_if if1 ();
    gowin_rpll_if if2 ();
    gowin_rpll_if if3 ();
    gowin_rpll #(.MULT(1), .DIV(2), .LOCK_CYCLES(16), .SDIV(4)) u0 (.clkin(clkin), .reset(reset), .pll(if0));
    gowin_rpll #(.MULT(1), .DIV(8), .LOCK_CYCLES(3), .SDIV(4)) u1 (.clkin(clkin), .reset(reset), .pll(if1));
    gowin_rpll #(.MULT(3), .DIV(20), .LOCK_CYCLES(5), .SDIV(4)) u2 (.clkin(clkin), .reset(reset), .pll(if2));
    gowin_rpll #(.MULT(1), .DIV(4), .LOCK_CYCLES(4), .SDIV(4)) u3 (.clkin(clkin), .reset(reset), .pll(if3));
    // toggles after k edges = floor(2*MULT*k/DIV); rises = ceil(toggles/2)
    function automatic logic [2:0] model(int mult, int div, int lc, int k);
        longint t, r;
        logic d;
        t = (longint'(k) * 2 * mult) / div;
        r = (t + 1) / 2;
`ifdef GOWIN_RPLL_CLKOUTD_EN
        d = ((r / 2) % 2) == 1;
`else
        d = 1'b0;
`endif
        return {d, r >= lc, (t % 2) == 1};
    endfunction
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, got, exp, n);
        end
    endtask
    task automatic chk_all();
        chk("u0_dlc", int'({if0.clkoutd, if0.lock, if0.clkout}), int'(model(1, 2, 16, n)));
        chk("u1_dlc", int'({if1.clkoutd, if1.lock, if1.clkout}), int'(model(1, 8, 3, n)));
        chk("u2_dlc", int'({if2.clkoutd, if2.lock, if2.clkout}), int'(model(3, 20, 5, n)));
        chk("u3_dlc", int'({if3.clkoutd, if3.lock, if3.clkout}), int'(model(1, 4, 4, n)));
    endtask
    task automatic chk_zero(input string tag);
        chk(tag, int'({if0.clkoutd, if0.lock, if0.clkout, if1.clkoutd, if1.lock, if1.clkout,
                      if2.clkoutd, if2.lock, if2.clkout, if3.clkoutd, if3.lock, if3.clkout}), 0);
    endtask
    initial begin
        int rises2, lock_edge, len;
        logic prev2;
        #1;
        chk_zero("reset_state");
        repeat (2) @(posedge clkin);
        @(negedge clkin);
        reset = 1'b0;
        n = 0;
        rises2 = 0;
        lock_edge = -1;
        prev2 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clkin);
            #1;
            n++;
            chk_all();
            if (if2.clkout && !prev2) rises2++;
            prev2 = if2.clkout;
            if (if3.lock && lock_edge < 0) lock_edge = n;
        end
        chk("u2_rises_in_60", rises2, 9);
        chk("u3_lock_edge", lock_edge, 14);
        for (int r = 0; r < 6; r++) begin
            len = int'($urandom_range(20, 150));
            for (int i = 0; i < len; i++) begin
                @(posedge clkin);
                #1;
                n++;
                chk_all();
            end
            #($urandom_range(1, 3));
            reset = 1'b1;
            #1;
            chk_zero("async_reset");
            @(posedge clkin);
            #1;
            chk_zero("reset_held");
            @(negedge clkin);
            reset = 1'b0;
            n = 0;
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clkin);
            #1;
            n++;
            chk_all();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
